// File: rtl/aes_pkg.sv
// aes_pkg: shared AES tables, key-length encodings, round constants and key-expansion FSM states.
package aes_pkg;
  localparam int MAX_WORDS = 60;
  localparam logic [1:0] KEYLEN_128 = 2'b01;
  localparam logic [1:0] KEYLEN_192 = 2'b10;
  localparam logic [1:0] KEYLEN_256 = 2'b11;
  localparam logic [5:0] NK_128 = 6'd4;
  localparam logic [5:0] NK_192 = 6'd6;
  localparam logic [5:0] NK_256 = 6'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;
  typedef enum logic {IDLE, EXPAND} state_t;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [0:10][7:0] RCON = 88'h00_01_02_04_08_10_20_40_80_1b_36;
  function automatic logic [5:0] nk_of(input logic [1:0] kl);
    return kl == KEYLEN_128 ? NK_128 : kl == KEYLEN_192 ? NK_192 : kl == KEYLEN_256 ? NK_256 : 6'd0;
  endfunction
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    return kl == KEYLEN_128 ? NR_128 : kl == KEYLEN_192 ? NR_192 : kl == KEYLEN_256 ? NR_256 : 4'd0;
  endfunction
endpackage

// File: rtl/aes_subword.sv
// aes_subword: four parallel S-box lookups on a 32-bit word.
module aes_subword import aes_pkg::*; (
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: AES-128/192/256 key schedule, one word per cycle, 128-bit round-key read port.
// AES_KEY_REVERSE_ADDR_EN maps subkey_addr a to round Nr-a for count-up decryption.
module aes_key_expand import aes_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         ready,
  output logic         busy,
  input  logic [3:0]   subkey_addr,
  output logic [127:0] subkey
);
  state_t state;
  logic [31:0] w [MAX_WORDS];
  logic [1:0] klen;
  logic [5:0] cnt, nk, total, base;
  logic [3:0] nr, round, ri;
  logic [2:0] phase;
  logic [31:0] prev, rot, sub, temp, nxt;
  assign nk = nk_of(klen);
  assign nr = nr_of(klen);
  assign total = {nr + 4'd1, 2'b00};
  assign prev = w[cnt - 6'd1];
  assign rot = {prev[23:0], prev[31:24]};
  aes_subword u_sub (.a(phase == 3'd0 ? rot : prev), .y(sub));
  // phase tracks i mod Nk and ri tracks i/Nk, avoiding a divider
  assign temp = phase == 3'd0 ? sub ^ {RCON[ri], 24'h0} : (nk == NK_256 && phase == 3'd4) ? sub : prev;
  assign nxt = w[cnt - nk] ^ temp;
`ifdef AES_KEY_REVERSE_ADDR_EN
  assign round = nr - subkey_addr;
`else
  assign round = subkey_addr;
`endif
  assign base = {round, 2'b00};
  assign subkey = subkey_addr > nr ? '0 : {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      klen <= '0;
      phase <= '0;
      ri <= '0;
      for (int k = 0; k < MAX_WORDS; k++) w[k] <= '0;
    end else if (state == IDLE) begin
      if (start && key_len != 2'b00) begin
        state <= EXPAND;
        ready <= 1'b0;
        busy <= 1'b1;
        klen <= key_len;
        cnt <= nk_of(key_len);
        phase <= '0;
        ri <= 4'd1;
        for (int k = 0; k < 8; k++)
          if (k < int'(nk_of(key_len))) w[k] <= key[255 - 32*k -: 32];
      end
    end else begin
      w[cnt] <= nxt;
      cnt <= cnt + 6'd1;
      phase <= phase == 3'(nk - 6'd1) ? 3'd0 : phase + 3'd1;
      if (phase == 3'd0) ri <= ri + 4'd1;
      if (cnt == total - 6'd1) begin
        state <= IDLE;
        ready <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: random and known-answer checks of aes_key_expand against a GF(2^8)-derived reference.
module tb_aes_key_expand;
  logic clk = 0, reset, start;
  logic [1:0] key_len;
  logic [255:0] key;
  logic ready, busy;
  logic [3:0] subkey_addr;
  logic [127:0] subkey;
  int checks = 0, errors = 0;
  logic [7:0] sb [256];
  logic [31:0] mw [60];
  int mnr, mnk;
  always #5 clk = ~clk;
  aes_key_expand dut (.clk(clk), .reset(reset), .start(start), .key_len(key_len), .key(key),
    .ready(ready), .busy(busy), .subkey_addr(subkey_addr), .subkey(subkey));
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction
  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r = 8'h01;
    for (int i = 1; i < n; i++) r = xt(r);
    return r;
  endfunction
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask
  task automatic model(input logic [255:0] k, input logic [1:0] kl);
    logic [31:0] t;
    mnk = kl == 2'd1 ? 4 : kl == 2'd2 ? 6 : 8;
    mnr = mnk + 6;
    for (int i = 0; i < mnk; i++) mw[i] = k[255 - 32*i -: 32];
    for (int i = mnk; i < 4 * (mnr + 1); i++) begin
      t = mw[i-1];
      if (i % mnk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon(i / mnk), 24'h0};
      else if (mnk == 8 && i % 8 == 4) t = subw(t);
      mw[i] = mw[i-mnk] ^ t;
    end
  endtask
  function automatic logic [3:0] addr_of(input int r);
`ifdef AES_KEY_REVERSE_ADDR_EN
    return 4'(mnr - r);
`else
    return 4'(r);
`endif
  endfunction
  function automatic logic [127:0] exp_sub(input int a);
    int r;
    if (a > mnr) return '0;
`ifdef AES_KEY_REVERSE_ADDR_EN
    r = mnr - a;
`else
    r = a;
`endif
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      subkey_addr = 4'(a);
      @(negedge clk);
      check($sformatf("%s_a%0d", tag, a), subkey, exp_sub(a));
    end
  endtask
  task automatic run(input logic [255:0] k, input logic [1:0] kl, output int lat);
    key = k;
    key_len = kl;
    start = 1;
    tick();
    start = 0;
    check("busy_on", busy, 1);
    check("rdy_drop", ready, 0);
    lat = 0;
    while (!ready && lat < 100) begin
      tick();
      lat++;
    end
    check("busy_off", busy, 0);
  endtask
  logic [255:0] vk [3];
  logic [127:0] vlast [3];
  int vlat [3];
  initial begin
    int lat, n;
    logic [255:0] ka, kb;
    logic [1:0] kl;
    vk[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    vk[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    vk[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    vlast[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vlast[1] = 128'he98ba06f448c773c8ecc720401002202;
    vlast[2] = 128'hfe4890d1e6188d0b046df344706c631e;
    vlat = '{40, 46, 52};
    build_sbox();
    reset = 1; start = 0; key_len = 0; key = 0; subkey_addr = 0;
    repeat (3) tick();
    reset = 0;
    tick();
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_sub", subkey, 0);
    for (int v = 0; v < 3; v++) begin
      run(vk[v], 2'(v + 1), lat);
      model(vk[v], 2'(v + 1));
      check($sformatf("kat%0d_lat", v), lat, vlat[v]);
      subkey_addr = addr_of(0);
      @(negedge clk);
      check($sformatf("kat%0d_first", v), subkey, vk[v][255:128]);
      subkey_addr = addr_of(mnr);
      @(negedge clk);
      check($sformatf("kat%0d_last", v), subkey, vlast[v]);
      check_all($sformatf("kat%0d", v));
    end
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key_len = 2'b00;
    start = 1;
    tick();
    start = 0;
    tick();
    check("inv_ready", ready, 1);
    check("inv_busy", busy, 0);
    check_all("inv");
    ka = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key = ka; key_len = 2'd1; start = 1;
    tick();
    n = 0;
    while (!ready && n < 100) begin
      start = n == 9;
      if (n == 9) begin key = kb; key_len = 2'd3; end
      tick();
      n++;
    end
    start = 0;
    check("restart_lat", n, 40);
    model(ka, 2'd1);
    check_all("restart");
    ka = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    key = ka; key_len = 2'd1; start = 1;
    tick();
    start = 0;
    repeat (19) tick();
    reset = 1;
    tick();
    reset = 0;
    subkey_addr = 0;
    #1;
    check("abort_ready", ready, 0);
    check("abort_busy", busy, 0);
    check("abort_sub", subkey, 0);
    run(ka, 2'd1, lat);
    model(ka, 2'd1);
    check("fresh_lat", lat, 40);
    check_all("fresh");
    for (int r = 0; r < 6; r++) begin
      ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kl = 2'($urandom_range(1, 3));
      run(ka, kl, lat);
      model(ka, kl);
      check($sformatf("rnd%0d_lat", r), lat, 4 * (mnr + 1) - mnk);
      check_all($sformatf("rnd%0d", r));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Upstream neighbour of the AES decrypt/encrypt round engines.
- Expands a 128/192/256-bit cipher key into the full round-key schedule, one 32-bit word per cycle, and stores it in an internal 60-word register file.
- Serves 128-bit round keys combinationally on a 4-bit address, matching the engine's subkey/subkey_addr interface.

Parameters:
- MAX_WORDS, 60, storage depth in 32-bit words (Nr=14 -> 4*(14+1)); fixed, not user-tuned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request expansion; sampled only while idle.
- key_len  input  2  01=AES-128, 10=AES-192, 11=AES-256, 00=invalid.
- key  input  256  cipher key, MSB-aligned: 128-bit uses key[255:128], 192-bit uses key[255:64].
- ready  output  1  schedule complete and valid.
- busy  output  1  expansion in progress.
- subkey_addr  input  4  round-key index 0..Nr.
- subkey  output  128  round key {w[4a], w[4a+1], w[4a+2], w[4a+3]}, w[4a] in [127:96].

Behaviour:
- Reset (synchronous, active-high): ready=0, busy=0, state=IDLE, word counter=0, latched Nk/total=0, all storage words cleared to 0. Reset mid-expansion aborts immediately, with the same values.
- Nk/Nr/total words: 128 -> 4/10/44; 192 -> 6/12/52; 256 -> 8/14/60.
- IDLE:
  - start=1 with key_len!=00 at edge E0: load w[0..Nk-1] from key, latch key_len, counter i=Nk, ready<=0, busy<=1, go to EXPAND.
  - start with key_len=00 is ignored; state and ready are unchanged.
- EXPAND: each edge writes w[i] and increments i.
  - temp=w[i-1].
  - If i mod Nk==0: temp=SubWord(RotWord(temp)) xor {Rcon[i/Nk],24'h0}.
  - Else if Nk==8 and i mod 8==4: temp=SubWord(temp).
  - w[i]=w[i-Nk] xor temp.
  - The edge that writes w[total-1] also sets ready<=1, busy<=0, state=IDLE.
- Latency: ready first high after edge E(total-Nk), i.e. 40 / 46 / 52 cycles after the start edge for 128 / 192 / 256.
- Rcon: 8-bit, starts at 01 and doubles in GF(2^8) (…80 -> 1b -> 36); index 1..10.
- start while busy is ignored and does not restart.
- New start while ready=1: accepted. ready drops on the following edge and the schedule is overwritten.
- Read port:
  - subkey is purely combinational from storage and subkey_addr.
  - subkey_addr > Nr of the latched key_len returns 128'h0.
  - Reads during EXPAND return current storage contents (partially updated). Consumers must wait for ready.
- key and key_len are sampled only at the start edge. Later changes have no effect until the next accepted start.

Optional Feature:
- Macro AES_KEY_REVERSE_ADDR_EN.
- Defined: the read port maps subkey_addr a to round index Nr-a. Addr 0 returns the last round key, so the decrypt engine can count up. a>Nr still returns 0.
- Undefined: direct mapping (addr a -> round a).
- Expansion timing and storage are identical in both builds.

Decomposition:
- Shared package aes_pkg holds:
  - S-box table (256x8) and Rcon table.
  - Key-length encodings KEYLEN_128/192/256.
  - NK_x and NR_x constants.
  - FSM state enum (IDLE, EXPAND).
- One sub-module, aes_subword: four parallel S-box lookups on 32 bits, combinational. RotWord is inline wiring.

Test Plan:
- AES-128: key 2b7e151628aed2a6abf7158809cf4f3c, start -> ready after 40 cycles; addr 0 = key; addr 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; addr 11..15 = 0.
- AES-192: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> ready after 46 cycles; addr 12 = e98ba06f448c773c8ecc720401002202.
- AES-256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> ready after 52 cycles; addr 14 = fe4890d1e6188d0b046df344706c631e.
- start with key_len=00 -> ready/busy unchanged. start pulsed at cycle 10 of a 128 expansion -> completion still at cycle 40 with the original key's result.
- reset asserted at cycle 20 of an expansion -> next edge ready=0, busy=0, addr 0 reads 0. A fresh 128 start then completes correctly in 40 cycles.
- With AES_KEY_REVERSE_ADDR_EN, AES-128 vector: addr 0 = d014f9a8c9ee2589e13f0cc8b6630ca6, addr 10 = 2b7e151628aed2a6abf7158809cf4f3c.
